// File: rtl/cache_write_ctrl.sv
// Set-associative, write-back, write-allocate cache controller with word-serial memory refill/evict.
// Define CACHE_LRU_EN for true-LRU replacement; otherwise each set uses a round-robin pointer.
module cache_write_ctrl #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 12,
    parameter int OFFSET_W = 4,
    parameter int INDEX_W  = 3,
    parameter int WAYS     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int WORDS = 2 ** OFFSET_W;
    localparam int SETS  = 2 ** INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int WAY_W = $clog2(WAYS);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        REFILL,
        DONE
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0]   req_addr;
    logic                req_we;
    logic [DATA_W-1:0]   req_wdata;
    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_index;
    logic [OFFSET_W-1:0] req_offset;

    logic [DATA_W-1:0] data_arr  [WAYS][SETS][WORDS];
    logic [TAG_W-1:0]  tag_arr   [WAYS][SETS];
    logic              valid_arr [WAYS][SETS];
    logic              dirty_arr [WAYS][SETS];

    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic                invalid_found;
    logic [WAY_W-1:0]    invalid_way;
    logic [WAY_W-1:0]    repl_way;
    logic [WAY_W-1:0]    victim_sel;
    logic [WAY_W-1:0]    victim;
    logic                victim_dirty;
    logic [OFFSET_W-1:0] word_cnt;
    logic [OFFSET_W-1:0] cnt_next;
    logic                last_word;
    logic                beat;
    logic                lookup_hit;
    logic                refill_done;
    logic [TAG_W-1:0]    phase_tag;

    assign req_tag    = req_addr[ADDR_W-1 -: TAG_W];
    assign req_index  = req_addr[OFFSET_W +: INDEX_W];
    assign req_offset = req_addr[OFFSET_W-1:0];

    // Scan high-to-low so the lowest-numbered matching/invalid way wins.
    always_comb begin
        hit           = 1'b0;
        hit_way       = '0;
        invalid_found = 1'b0;
        invalid_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_arr[w][req_index] && (tag_arr[w][req_index] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_arr[w][req_index]) begin
                invalid_found = 1'b1;
                invalid_way   = WAY_W'(w);
            end
        end
    end

    assign victim_sel   = invalid_found ? invalid_way : repl_way;
    assign victim_dirty = valid_arr[victim_sel][req_index] && dirty_arr[victim_sel][req_index];
    assign cnt_next     = word_cnt + 1'b1;
    assign last_word    = &word_cnt;
    assign beat         = ((state == WRITEBACK) || (state == REFILL)) && mem_req && mem_ack;
    assign lookup_hit   = (state == LOOKUP) && hit;
    assign refill_done  = (state == REFILL) && beat && last_word;
    assign phase_tag    = (state == WRITEBACK) ? tag_arr[victim][req_index] : req_tag;

`ifdef CACHE_LRU_EN
    logic [WAY_W-1:0] age [SETS][WAYS];
    logic             touch;
    logic [WAY_W-1:0] touch_way;
    logic [WAY_W-1:0] touch_age;

    always_comb begin
        repl_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (age[req_index][w] == WAY_W'(WAYS - 1)) begin
                repl_way = WAY_W'(w);
            end
        end
    end

    assign touch     = lookup_hit || refill_done;
    assign touch_way = refill_done ? victim : hit_way;
    // A refilled way counts as oldest, so the others age even when it was previously invalid.
    assign touch_age = refill_done ? WAY_W'(WAYS - 1) : age[req_index][hit_way];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age[s][w] <= '0;
                end
            end
        end else if (touch) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == touch_way) begin
                    age[req_index][w] <= '0;
                end else if (age[req_index][w] < touch_age) begin
                    age[req_index][w] <= age[req_index][w] + 1'b1;
                end
            end
        end
    end
`else
    logic [WAY_W-1:0] rr_ptr [SETS];

    assign repl_way = rr_ptr[req_index];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                rr_ptr[s] <= '0;
            end
        end else if (refill_done) begin
            rr_ptr[req_index] <= rr_ptr[req_index] + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    state_next = DONE;
                end else if (victim_dirty) begin
                    state_next = WRITEBACK;
                end else begin
                    state_next = REFILL;
                end
            end
            WRITEBACK: begin
                if (beat && last_word) begin
                    state_next = REFILL;
                end
            end
            REFILL: begin
                if (refill_done) begin
                    state_next = LOOKUP;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign cpu_ready = (state == IDLE);
    assign cpu_done  = (state == DONE);

    // Memory outputs are registered: each phase spends one cycle loading word 0 before mem_req rises.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_addr  <= '0;
            req_we    <= 1'b0;
            req_wdata <= '0;
            victim    <= '0;
            word_cnt  <= '0;
            cpu_rdata <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_arr[w][s] <= 1'b0;
                    dirty_arr[w][s] <= 1'b0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        req_addr  <= cpu_addr;
                        req_we    <= cpu_we;
                        req_wdata <= cpu_wdata;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        cpu_rdata <= req_we ? req_wdata : data_arr[hit_way][req_index][req_offset];
                        if (req_we) begin
                            dirty_arr[hit_way][req_index] <= 1'b1;
                        end
                    end else begin
                        victim                           <= victim_sel;
                        valid_arr[victim_sel][req_index] <= 1'b0;
                    end
                end
                WRITEBACK, REFILL: begin
                    if (!mem_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= (state == WRITEBACK);
                        mem_addr  <= {phase_tag, req_index, word_cnt};
                        mem_wdata <= (state == WRITEBACK) ? data_arr[victim][req_index][word_cnt] : '0;
                    end else if (mem_ack) begin
                        if (last_word) begin
                            mem_req  <= 1'b0;
                            mem_we   <= 1'b0;
                            word_cnt <= '0;
                            if (state == WRITEBACK) begin
                                dirty_arr[victim][req_index] <= 1'b0;
                            end else begin
                                valid_arr[victim][req_index] <= 1'b1;
                                dirty_arr[victim][req_index] <= 1'b0;
                            end
                        end else begin
                            word_cnt  <= cnt_next;
                            mem_addr  <= {phase_tag, req_index, cnt_next};
                            mem_wdata <= (state == WRITEBACK) ?
                                         data_arr[victim][req_index][cnt_next] : '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Data and tag storage carry no reset; validity alone decides whether their contents matter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (lookup_hit && req_we) begin
                data_arr[hit_way][req_index][req_offset] <= req_wdata;
            end
            if ((state == REFILL) && beat) begin
                data_arr[victim][req_index][word_cnt] <= mem_rdata;
            end
            if (refill_done) begin
                tag_arr[victim][req_index] <= req_tag;
            end
        end
    end

endmodule
